dmem_io: RTL and testbench

DMEM_IO -- requirements
Module: dmem_io

---
 rtl/dmem_io.sv | 138 +++++++++++++
 tb/tb_dmem_io.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_io.sv
// Data memory plus memory-mapped IO: word RAM, synchronized switches/button,
// an 8-digit multiplexed seven-segment display and a free-running cycle counter.
module dmem_io #(
    parameter int unsigned RAM_AW    = 6,
    parameter int unsigned SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam logic [SCAN_BITS-1:0] SCAN_ONE = SCAN_BITS'(1);

    logic [31:0] mem_q [0:(1<<RAM_AW)-1];

    logic [RAM_AW-1:0]    ram_idx;
    logic                 is_io;
    logic [1:0]           io_sel;
    logic                 ram_we;
    logic                 disp_we;
    logic                 btn_clr;

    logic [15:0]          sw1_q, sw1_d, sw2_q, sw2_d;
    logic                 btn1_q, btn1_d, btn2_q, btn2_d, btn3_q, btn3_d;
    logic                 pressed_q, pressed_d;
    logic [31:0]          disp_q, disp_d;
    logic [31:0]          cyc_q, cyc_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;

    logic [2:0]           digit;
    logic [3:0]           nibble;
    logic                 unused_bits;

    assign ram_idx = aluout[RAM_AW+1:2];
    assign is_io   = aluout[15];
    assign io_sel  = aluout[3:2];
    assign unused_bits = ^{aluout[31:16], aluout[14:RAM_AW+2], aluout[1:0]};

    // Reset also masks RAM writes so an in-flight store cannot land while held in reset.
    assign ram_we  = memwrite & ~is_io & reset;
    assign disp_we = memwrite & is_io & (io_sel == 2'd2);
    assign btn_clr = memwrite & is_io & (io_sel == 2'd1) & writedata[0];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= writedata;
        end
    end

    always_comb begin
        sw1_d  = sw;
        sw2_d  = sw1_q;
        btn1_d = btn;
        btn2_d = btn1_q;
        btn3_d = btn2_q;
        disp_d = disp_we ? writedata : disp_q;
        cyc_d  = cyc_q + 32'd1;
        scan_d = scan_q + SCAN_ONE;
        // A fresh press outranks a same-cycle clear so no press is ever lost.
        if (btn2_q && !btn3_q) begin
            pressed_d = 1'b1;
        end else if (btn_clr) begin
            pressed_d = 1'b0;
        end else begin
            pressed_d = pressed_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw1_q     <= '0;
            sw2_q     <= '0;
            btn1_q    <= 1'b0;
            btn2_q    <= 1'b0;
            btn3_q    <= 1'b0;
            pressed_q <= 1'b0;
            disp_q    <= '0;
            cyc_q     <= '0;
            scan_q    <= '0;
        end else begin
            sw1_q     <= sw1_d;
            sw2_q     <= sw2_d;
            btn1_q    <= btn1_d;
            btn2_q    <= btn2_d;
            btn3_q    <= btn3_d;
            pressed_q <= pressed_d;
            disp_q    <= disp_d;
            cyc_q     <= cyc_d;
            scan_q    <= scan_d;
        end
    end

    always_comb begin
        if (is_io) begin
            case (io_sel)
                2'd0:    readdata = {16'b0, sw2_q};
                2'd1:    readdata = {31'b0, pressed_q};
                2'd2:    readdata = disp_q;
                default: readdata = cyc_q;
            endcase
        end else begin
            readdata = mem_q[ram_idx];
        end
    end

    assign digit  = scan_q[SCAN_BITS-1 -: 3];
    assign nibble = disp_q[{digit, 2'b00} +: 4];
    assign an     = ~(8'b1 << digit);

    always_comb begin
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io: RAM, IO registers, button latch, display scan,
// cycle counter and asynchronous reset behaviour.
module tb_dmem_io;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] sw;
    logic        btn;
    logic [7:0]  an;
    logic [6:0]  seg;

    int tests = 0;
    int fails = 0;
    logic [31:0] tb_cyc;
    logic [31:0] first_rd;
    logic [31:0] disp_val;
    logic [2:0]  exp_d;
    logic [7:0]  exp_an;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    dmem_io #(.RAM_AW(6), .SCAN_BITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .sw        (sw),
        .btn       (btn),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    // Independent count of edges since reset release; expected CYC and scan phase.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        aluout    = addr;
        writedata = data;
        memwrite  = 1'b1;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        aluout   = addr;
        memwrite = 1'b0;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b0; memwrite = 1'b0; aluout = '0; writedata = '0;
        sw = '0; btn = 1'b0;
        #3;
        check("rst_an", {24'b0, an}, 32'h0000_00FE);
        check("rst_seg", {25'b0, seg}, 32'h0000_0040);
        bus_read("rst_disp", 32'h8008, 32'h0);
        bus_read("rst_cyc", 32'h800C, 32'h0);
        bus_read("rst_btn", 32'h8004, 32'h0);
        bus_read("rst_sw", 32'h8000, 32'h0);
        @(posedge clk); #2;
        reset = 1'b1;

        // RAM write/read and address aliasing
        bus_write(32'h0000_0010, 32'hDEAD_BEEF);
        bus_write(32'h0000_0014, 32'h1234_5678);
        bus_read("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        bus_read("ram_14", 32'h0000_0014, 32'h1234_5678);
        bus_read("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);

        // Read-after-write in the same cycle sees old data
        aluout = 32'h10; writedata = 32'hCAFE_F00D; memwrite = 1'b1;
        #1;
        check("raw_old", readdata, 32'hDEAD_BEEF);
        tick();
        memwrite = 1'b0;
        bus_read("raw_new", 32'h10, 32'hCAFE_F00D);

        // Switch synchronizer
        sw = 16'hA5C3;
        bus_read("sw_pre", 32'h8000, 32'h0);
        tick();
        bus_read("sw_e1", 32'h8000, 32'h0);
        tick();
        bus_read("sw_e2", 32'h8000, 32'h0000_A5C3);
        bus_write(32'h8000, 32'hFFFF_FFFF);
        bus_read("sw_wr_ign", 32'h8000, 32'h0000_A5C3);

        // Button latch
        btn = 1'b1;
        tick();
        bus_read("btn_e1", 32'h8004, 32'h0);
        tick();
        bus_read("btn_e2", 32'h8004, 32'h0);
        tick();
        bus_read("btn_e3", 32'h8004, 32'h1);
        tick(); tick();
        btn = 1'b0;
        tick(); tick(); tick(); tick();
        bus_read("btn_hold", 32'h8004, 32'h1);
        bus_write(32'h8004, 32'h0000_0000);
        bus_read("btn_wr0", 32'h8004, 32'h1);
        bus_write(32'h8004, 32'h0000_0001);
        bus_read("btn_clr", 32'h8004, 32'h0);
        btn = 1'b1;
        tick(); tick();
        bus_write(32'h8004, 32'h0000_0001);
        bus_read("btn_set_wins", 32'h8004, 32'h1);
        btn = 1'b0;

        // Display scan
        disp_val = 32'h0123_456F;
        bus_write(32'h8008, disp_val);
        bus_read("disp_rd", 32'h8008, disp_val);
        for (int i = 0; i < 9; i++) begin
            exp_d  = tb_cyc[2:0];
            exp_an = ~(8'b1 << exp_d);
            check("scan_an", {24'b0, an}, {24'b0, exp_an});
            check("scan_seg", {25'b0, seg}, {25'b0, seg_tab[disp_val[{exp_d, 2'b00} +: 4]]});
            tick();
        end

        // Cycle counter
        bus_read("cyc_abs", 32'h800C, tb_cyc);
        first_rd = readdata;
        tick(); tick(); tick(); tick(); tick();
        bus_read("cyc_delta", 32'h800C, first_rd + 32'd5);
        bus_write(32'h800C, 32'h0000_1234);
        bus_read("cyc_wr_ign", 32'h800C, tb_cyc);
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_q;
        bus_read("cyc_max", 32'h800C, 32'hFFFF_FFFF);
        tick();
        bus_read("cyc_wrap", 32'h800C, 32'h0);

        // Asynchronous reset mid-run with a pending DISP write
        aluout = 32'h8008; writedata = 32'h5555_5555; memwrite = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("arst_disp", readdata, 32'h0);
        check("arst_an", {24'b0, an}, 32'h0000_00FE);
        check("arst_seg", {25'b0, seg}, 32'h0000_0040);
        aluout = 32'h800C;
        #1;
        check("arst_cyc", readdata, 32'h0);
        @(posedge clk); #2;
        aluout = 32'h8008;
        #1;
        check("arst_disp_edge", readdata, 32'h0);
        memwrite = 1'b0;
        bus_read("arst_ram10", 32'h10, 32'hCAFE_F00D);
        bus_read("arst_ram14", 32'h14, 32'h1234_5678);
        bus_read("arst_btn", 32'h8004, 32'h0);
        reset = 1'b1;
        tick(); tick(); tick();
        bus_read("post_cyc", 32'h800C, tb_cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
